// File: rtl/midi_param_rx.sv
// MIDI receiver: 2-flop synchroniser, UART byte framer and a running-status parser
// that drives a mono note gate and a bank of CC-mapped 7-bit parameter registers.
module midi_param_rx #(
    parameter int         CLK_HZ     = 100_000_000,
    parameter int         BAUD       = 31250,
    parameter int         NUM_PARAMS = 8,
    parameter int         CC_BASE    = 20,
    parameter logic [3:0] MIDI_CH    = 4'd0,
    parameter bit         OMNI       = 1'b0
) (
    input  logic                      clk100,
    input  logic                      rst_n,
    input  logic                      midi_rx,
    output logic                      gate,
    output logic [6:0]                note,
    output logic [6:0]                velocity,
    output logic [NUM_PARAMS*7-1:0]   param_flat,
    output logic                      param_wr,
    output logic [3:0]                param_addr,
    output logic                      byte_valid,
    output logic [7:0]                rx_byte,
    output logic                      frame_err
);

    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int CW      = $clog2(BIT_CYC + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(BIT_CYC / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_state_t;
    typedef enum logic [1:0] {P_IDLE, P_D1, P_D2} parse_state_t;

    logic        sync1_q, sync2_q, rxPrev_q;
    logic [1:0]  settle_q, settle_d;
    logic        armed_q, armed_d;
    logic        rxS;

    uart_state_t uState_q, uState_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [7:0]  shift_q, shift_d;
    logic        byteValid_q, byteValid_d;
    logic [7:0]  rxByte_q, rxByte_d;
    logic        frameErr_q, frameErr_d;

    parse_state_t pState_q, pState_d;
    logic [7:0]  runStat_q, runStat_d;
    logic        runValid_q, runValid_d;
    logic [6:0]  data1_q, data1_d;
    logic        gate_q, gate_d;
    logic [6:0]  note_q, note_d;
    logic [6:0]  vel_q, vel_d;
    logic [NUM_PARAMS*7-1:0] params_q, params_d;
    logic        paramWr_q, paramWr_d;
    logic [3:0]  paramAddr_q, paramAddr_d;

    logic        msgDone, oneData, chOk;
    logic [6:0]  msgD1, msgD2;
    int          ccIdx;

    assign rxS = sync2_q;

    // A start edge is only trusted once the line has been seen high after reset,
    // so a byte cut short by reset cannot retrigger reception on its low tail.
    always_comb begin
        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        armed_d  = armed_q | ((settle_q == 2'd3) & rxS);
    end

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            rxPrev_q <= 1'b1;
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= midi_rx;
            sync2_q  <= sync1_q;
            rxPrev_q <= sync2_q;
            settle_q <= settle_d;
            armed_q  <= armed_d;
        end
    end

    always_comb begin
        uState_d    = uState_q;
        cnt_d       = cnt_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        byteValid_d = 1'b0;
        rxByte_d    = rxByte_q;
        frameErr_d  = 1'b0;
        case (uState_q)
            IDLE: begin
                cnt_d = '0;
                if (armed_q && rxPrev_q && !rxS) uState_d = START;
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d    = '0;
                    bitIdx_d = 3'd0;
                    uState_d = rxS ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rxS, shift_q[7:1]};
                    if (bitIdx_q == 3'd7) uState_d = STOP;
                    else                  bitIdx_d = bitIdx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rxS) begin
                        byteValid_d = 1'b1;
                        rxByte_d    = shift_q;
                        uState_d    = IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        uState_d   = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: if (rxS) uState_d = IDLE;
            default:   uState_d = IDLE;
        endcase
    end

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            uState_q    <= IDLE;
            cnt_q       <= '0;
            bitIdx_q    <= 3'd0;
            shift_q     <= 8'd0;
            byteValid_q <= 1'b0;
            rxByte_q    <= 8'd0;
            frameErr_q  <= 1'b0;
        end else begin
            uState_q    <= uState_d;
            cnt_q       <= cnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            byteValid_q <= byteValid_d;
            rxByte_q    <= rxByte_d;
            frameErr_q  <= frameErr_d;
        end
    end

    assign oneData = (runStat_q[7:4] == 4'hC) || (runStat_q[7:4] == 4'hD);
    assign chOk    = OMNI || (runStat_q[3:0] == MIDI_CH);

    // Real-time bytes (F8..FF) fall through untouched; a completed message is
    // decoded in the same cycle so every output lands one cycle after the strobe.
    always_comb begin
        pState_d    = pState_q;
        runStat_d   = runStat_q;
        runValid_d  = runValid_q;
        data1_d     = data1_q;
        gate_d      = gate_q;
        note_d      = note_q;
        vel_d       = vel_q;
        params_d    = params_q;
        paramWr_d   = 1'b0;
        paramAddr_d = paramAddr_q;
        msgDone     = 1'b0;
        msgD1       = data1_q;
        msgD2       = 7'd0;
        ccIdx       = 0;
        if (byteValid_q && rxByte_q < 8'hF8) begin
            if (rxByte_q >= 8'hF0) begin
                runValid_d = 1'b0;
                pState_d   = P_IDLE;
            end else if (rxByte_q[7]) begin
                runStat_d  = rxByte_q;
                runValid_d = 1'b1;
                pState_d   = P_D1;
            end else if (pState_q == P_D2) begin
                msgDone  = 1'b1;
                msgD2    = rxByte_q[6:0];
                pState_d = P_IDLE;
            end else if (runValid_q) begin
                if (oneData) begin
                    msgDone  = 1'b1;
                    msgD1    = rxByte_q[6:0];
                    pState_d = P_IDLE;
                end else begin
                    data1_d  = rxByte_q[6:0];
                    pState_d = P_D2;
                end
            end
        end
        if (msgDone && chOk) begin
            case (runStat_q[7:4])
                4'h9: begin
                    if (msgD2 != 7'd0) begin
                        gate_d = 1'b1;
                        note_d = msgD1;
                        vel_d  = msgD2;
                    end else if (note_q == msgD1) begin
                        gate_d = 1'b0;
                    end
                end
                4'h8: if (note_q == msgD1) gate_d = 1'b0;
                4'hB: begin
                    ccIdx = int'(msgD1) - CC_BASE;
                    for (int k = 0; k < NUM_PARAMS; k++) begin
                        if (ccIdx == k) begin
                            params_d[k*7 +: 7] = msgD2;
                            paramAddr_d        = 4'(k);
                            paramWr_d          = 1'b1;
                        end
                    end
                    if (msgD1 == 7'd123) gate_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            pState_q    <= P_IDLE;
            runStat_q   <= 8'd0;
            runValid_q  <= 1'b0;
            data1_q     <= 7'd0;
            gate_q      <= 1'b0;
            note_q      <= 7'd0;
            vel_q       <= 7'd0;
            params_q    <= '0;
            paramWr_q   <= 1'b0;
            paramAddr_q <= 4'd0;
        end else begin
            pState_q    <= pState_d;
            runStat_q   <= runStat_d;
            runValid_q  <= runValid_d;
            data1_q     <= data1_d;
            gate_q      <= gate_d;
            note_q      <= note_d;
            vel_q       <= vel_d;
            params_q    <= params_d;
            paramWr_q   <= paramWr_d;
            paramAddr_q <= paramAddr_d;
        end
    end

    assign gate       = gate_q;
    assign note       = note_q;
    assign velocity   = vel_q;
    assign param_flat = params_q;
    assign param_wr   = paramWr_q;
    assign param_addr = paramAddr_q;
    assign byte_valid = byteValid_q;
    assign rx_byte    = rxByte_q;
    assign frame_err  = frameErr_q;

endmodule

// File: doc/midi_param_rx.md
MIDI_PARAM_RX -- requirements
Module: midi_param_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, MIDI line rate; BIT_CYC = CLK_HZ/BAUD (3200 at defaults).
REQ-003 SHALL have parameter NUM_PARAMS, default 8, range 1..16, number of CC-mapped parameter registers.
REQ-004 SHALL have parameter CC_BASE, default 20, controller number mapped to parameter 0.
REQ-005 SHALL have parameter MIDI_CH, default 0, 4-bit channel filter; parameter OMNI, default 0, where 1 accepts all channels.
REQ-006 SHALL have port clk100, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port midi_rx, input, 1 bit: asynchronous serial MIDI line, idle high.
REQ-009 SHALL have port gate, output, 1 bit: high while a note is held.
REQ-010 SHALL have port note, output, 7 bits: current note number.
REQ-011 SHALL have port velocity, output, 7 bits: current note-on velocity.
REQ-012 SHALL have port param_flat, output, NUM_PARAMS*7 bits: parameter k occupies bits [7k+6:7k].
REQ-013 SHALL have port param_wr, output, 1 bit: one-cycle pulse on each parameter update.
REQ-014 SHALL have port param_addr, output, 4 bits: index of the last written parameter.
REQ-015 SHALL have port byte_valid, output, 1 bit, and port rx_byte, output, 8 bits: the received-byte strobe and its data.
REQ-016 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.

Function
REQ-017 SHALL synchronise midi_rx through two flops before any use.
REQ-018 UART FSM SHALL use states IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE -> START on a synchronised falling edge.
- START: at BIT_CYC/2 cycles, if the line is low -> DATA; if high -> IDLE (glitch rejected).
REQ-019 DATA SHALL sample 8 bits LSB first, one every BIT_CYC cycles from the mid-start point, then move to STOP.
REQ-020 STOP SHALL sample BIT_CYC cycles after bit 7.
- High: the next cycle pulses byte_valid with rx_byte held stable until the next strobe, then IDLE.
- Low: pulse frame_err, discard the byte, enter WAIT_HIGH; WAIT_HIGH -> IDLE on the first synchronised high.
REQ-021 Parser SHALL act on each byte_valid, with all outputs updating one cycle after the strobe.
REQ-022 Bytes 0xF8..0xFF (real-time) SHALL be ignored without altering parser state or running status.
REQ-023 Bytes 0xF0..0xF7 SHALL clear running status and return the parser to P_IDLE.
REQ-024 Parser states P_IDLE, P_D1, P_D2 SHALL behave as follows:
- A status byte 0x80..0xEF stores running status and enters P_D1.
- A data byte (bit7=0) in P_IDLE with valid running status is taken as data1 and enters P_D2; without running status it is ignored.
- Any status byte arriving in P_D1/P_D2 aborts the pending message and restarts per its own type.
REQ-025 Status types other than 0x8n, 0x9n and 0xBn SHALL be consumed (1 or 2 data bytes per MIDI spec) with no output effect.
REQ-026 Messages whose channel differs from MIDI_CH SHALL be consumed with no output effect when OMNI=0.
REQ-027 Note-on with velocity>0 SHALL set gate=1 and load note and velocity, overriding any held note (last-note priority).
REQ-028 Note-off, or note-on with velocity 0, SHALL clear gate only if its note equals the held note; otherwise it is ignored.
REQ-029 A CC message with controller c, where CC_BASE <= c < CC_BASE+NUM_PARAMS, SHALL:
- write the value to parameter c-CC_BASE;
- set param_addr to that index;
- pulse param_wr for 1 cycle.
REQ-030 A CC outside that range SHALL be consumed with no write; CC 123 (all notes off) SHALL clear gate.
REQ-031 After a complete message, the parser SHALL return to P_IDLE with running status retained.

Reset
REQ-032 While rst_n=0 at a rising edge, all of the following SHALL hold:
- gate=0, note=0, velocity=0, param_flat all 0;
- param_wr=0, param_addr=0, byte_valid=0, rx_byte=0, frame_err=0;
- UART in IDLE, parser in P_IDLE, running status cleared, synchroniser flops set to 1.
REQ-033 Reset asserted mid-byte SHALL abandon the byte; after release, reception SHALL resume only on a fresh falling edge.

Verification
REQ-034 Sending 0x2F at 31250 baud -> one byte_valid with rx_byte=0x2F, no frame_err.
REQ-035 Sending 0x90 0x3C 0x64 -> gate=1, note=0x3C, velocity=0x64; then 0x3C 0x00 under running status -> gate=0.
REQ-036 Sending 0xB0 0x16 0x55 -> param_wr pulse, param_addr=2, param_flat[20:14]=0x55; 0xB0 0x05 0x10 -> no param_wr.
REQ-037 Inserting 0xF8 between 0x90 and 0x40 of 0x90 0x40 0x7F -> note=0x40 with gate=1 (real-time byte transparent).
REQ-038 A byte with stop bit forced low -> frame_err pulse, no byte_valid; the line held low 5 bit times, then a valid 0x91 0x30 0x10 with OMNI=0 and MIDI_CH=0 -> no gate change.
REQ-039 A 200 ns low glitch -> no byte_valid; rst_n pulsed low mid-byte -> outputs at reset values and the next full byte received correctly.
